axi_write_slave: RTL and testbench

- AXI3 write-channel responder: accepts a write address (AW), consumes the write-data burst (W) into a local byte-addressable word memory, and returns one write response (B).
- Sits on the slave side of the write interconnect, opposite the write master, as a memory-mapped write target.
- One outstanding transaction at a time.
- A registered device-side read port exposes memory contents to local logic and to the bench.

---
 rtl/axi_pkg.sv | 47 ++++
 rtl/axi_write_slave_mem.sv | 51 +++++
 rtl/axi_write_slave.sv | 184 ++++++++++++++++++
 tb/tb_axi_write_slave.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// axi_pkg
//   Shared AXI3 definitions for the write-channel responder: burst and
//   response encodings, ID/LEN widths, the write-slave state enumeration,
//   and helpers for WRAP length legality and per-beat address stepping.
package axi_pkg;

    localparam int ID_W  = 4;
    localparam int LEN_W = 4;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_e;

    // WRAP bursts must span 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [LEN_W-1:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

    // Address of the beat following 'addr'. WRAP keeps the upper bits of the
    // aligned block and lets only the in-block offset roll over.
    function automatic logic [31:0] next_addr(input logic [31:0]      addr,
                                              input logic [LEN_W-1:0] len,
                                              input logic [2:0]       size,
                                              input logic [1:0]       burst);
        logic [31:0] step;
        logic [31:0] mask;
        step = 32'd1 << size;
        mask = (({{(32-LEN_W){1'b0}}, len} + 32'd1) << size) - 32'd1;
        case (burst)
            BURST_INCR: return addr + step;
            BURST_WRAP: return (addr & ~mask) | ((addr + step) & mask);
            default:    return addr;
        endcase
    endfunction

endpackage

// File: rtl/axi_write_slave_mem.sv
// axi_write_slave_mem
//   DEPTH x BUSWIDTH word RAM with a byte-enabled write port and a registered
//   read port. Contents are not touched by reset; only the read register is.
//   A same-cycle read and write of one word returns the pre-write data.
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset (read register only)
//   i_we        write enable
//   i_wr_idx    write word index
//   i_wr_data   write data
//   i_wr_strb   byte enables for the write
//   i_rd_idx    read word index
//   o_rd_data   registered read data, one-cycle latency
module axi_write_slave_mem #(
    parameter int BUSWIDTH = 32,
    parameter int DEPTH    = 64
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_wr_idx,
    input  logic [BUSWIDTH-1:0]        i_wr_data,
    input  logic [BUSWIDTH/8-1:0]      i_wr_strb,
    input  logic [$clog2(DEPTH)-1:0]   i_rd_idx,
    output logic [BUSWIDTH-1:0]        o_rd_data
);

    logic [BUSWIDTH-1:0] r_mem [DEPTH];
    logic [BUSWIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < BUSWIDTH/8; b++) begin
                if (i_wr_strb[b]) begin
                    r_mem[i_wr_idx][b*8 +: 8] <= i_wr_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[i_rd_idx];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/axi_write_slave.sv
// axi_write_slave
//   AXI3 write-channel responder backed by a local word memory. Accepts one
//   address, consumes its W burst, returns one B response; one transaction
//   outstanding at a time. A registered read port exposes memory contents.
// Ports:
//   ACLK, ARESET                      clock / synchronous active-high reset
//   AW* (ID,ADDR,LEN,SIZE,BURST,...)  write address channel (LOCK/CACHE/PROT ignored)
//   W*  (ID,DATA,STRB,LAST,VALID)     write data channel, WREADY out
//   B*  (ID,RESP,VALID)               write response channel, BREADY in
//   rd_addr / rd_data                 device-side word read port, 1-cycle latency
//
//   state | meaning
//   IDLE  | AWREADY high, waiting for an address
//   DATA  | WREADY high, consuming beats of the burst
//   RESP  | BVALID high, holding BID/BRESP until BREADY
module axi_write_slave
    import axi_pkg::*;
#(
    parameter int          BUSWIDTH  = 32,
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [3:0]                AWID,
    input  logic [31:0]               AWADDR,
    input  logic [3:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic [1:0]                AWLOCK,
    input  logic [3:0]                AWCACHE,
    input  logic [2:0]                AWPROT,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [3:0]                WID,
    input  logic [BUSWIDTH-1:0]       WDATA,
    input  logic [BUSWIDTH/8-1:0]     WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [3:0]                BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [$clog2(DEPTH)-1:0]  rd_addr,
    output logic [BUSWIDTH-1:0]       rd_data
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);

    wr_state_e          r_state;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [ID_W-1:0]    r_bid;
    logic [1:0]         r_bresp;
    logic [ID_W-1:0]    r_id;
    logic [31:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [2:0]         r_size;
    logic [1:0]         r_burst;
    logic [LEN_W-1:0]   r_beat;
    logic               r_err;
    logic               r_burst_err;

    logic [31:0]        w_offset;
    logic               w_in_range;
    logic [IDX_W-1:0]   w_word_idx;
    logic               w_beat_fire;
    logic               w_beat_err;
    logic               w_final_beat;
    logic               w_err_next;
    logic               w_we;
    logic               w_aw_burst_err;
    logic               w_unused;

    // Exclusive access is treated as a normal write (no monitor), so the
    // sideband attributes carry no meaning here.
    assign w_unused = ^{AWLOCK, AWCACHE, AWPROT};

    assign w_aw_burst_err = (AWSIZE > 3'd2) ||
                            (AWBURST == 2'b11) ||
                            ((AWBURST == BURST_WRAP) && !wrap_len_ok(AWLEN));

    // Unsigned offset: addresses below BASE_ADDR wrap to large values and
    // fall out of range along with those above the window.
    assign w_offset     = r_addr - BASE_ADDR;
    assign w_in_range   = (w_offset < MEM_BYTES);
    assign w_word_idx   = w_offset[IDX_W+1:2];

    assign w_beat_fire  = WVALID && r_wready;
    assign w_beat_err   = !w_in_range || (WID != r_id);
    assign w_final_beat = (r_beat == r_len);
    assign w_err_next   = r_err || r_burst_err || w_beat_err || (WLAST != w_final_beat);
    assign w_we         = w_beat_fire && !w_beat_err && !r_burst_err;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state     <= IDLE;
            r_awready   <= 1'b0;
            r_wready    <= 1'b0;
            r_bvalid    <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= RESP_OKAY;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_beat      <= '0;
            r_err       <= 1'b0;
            r_burst_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_awready <= 1'b1;
                    r_wready  <= 1'b0;
                    if (AWVALID && r_awready) begin
                        r_id        <= AWID;
                        r_addr      <= AWADDR;
                        r_len       <= AWLEN;
                        r_size      <= AWSIZE;
                        r_burst     <= AWBURST;
                        r_beat      <= '0;
                        r_err       <= 1'b0;
                        r_burst_err <= w_aw_burst_err;
                        r_awready   <= 1'b0;
                        r_wready    <= 1'b1;
                        r_state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_beat_fire) begin
                        r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
                        r_beat <= r_beat + 1'b1;
                        r_err  <= w_err_next;
                        if (WLAST || w_final_beat) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= w_err_next ? RESP_SLVERR : RESP_OKAY;
                            r_state  <= RESP;
                        end
                    end
                end
                RESP: begin
                    // AWREADY stays low this cycle; IDLE raises it next cycle.
                    if (r_bvalid && BREADY) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_bvalid  <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BID     = r_bid;
    assign BRESP   = r_bresp;

    axi_write_slave_mem #(
        .BUSWIDTH (BUSWIDTH),
        .DEPTH    (DEPTH)
    ) u_mem (
        .i_clk     (ACLK),
        .i_rst     (ARESET),
        .i_we      (w_we),
        .i_wr_idx  (w_word_idx),
        .i_wr_data (WDATA),
        .i_wr_strb (WSTRB),
        .i_rd_idx  (rd_addr),
        .o_rd_data (rd_data)
    );

endmodule

// File: tb/tb_axi_write_slave.sv
// tb_axi_write_slave
//   Directed bench for axi_write_slave. Expected B responses and memory
//   words are queued as stimulus is driven and popped when the DUT answers
//   (B channel) or when the read port is swept.
module tb_axi_write_slave;
    import axi_pkg::*;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic [1:0]  AWLOCK;
    logic [3:0]  AWCACHE;
    logic [2:0]  AWPROT;
    logic        AWVALID;
    logic        AWREADY;
    logic [3:0]  WID;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;

    int checks   = 0;
    int failures = 0;

    typedef struct { logic [5:0] idx; logic [31:0] data; } mem_exp_t;
    typedef struct { logic [3:0] id;  logic [1:0]  resp; } b_exp_t;
    mem_exp_t mem_q[$];
    b_exp_t   b_q[$];

    always #5 ACLK = ~ACLK;

    axi_write_slave #(.BUSWIDTH(32), .DEPTH(64), .BASE_ADDR(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
        .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output int waits);
        waits   = 0;
        AWID    = id;  AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        while (!AWREADY && waits < 50) begin
            @(posedge ACLK); #1;
            waits++;
        end
        if (waits >= 50) chk("aw_timeout", {31'b0, AWREADY}, 32'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [3:0] id, input logic [31:0] data,
                          input logic [3:0] strb, input logic last);
        int n = 0;
        WID = id; WDATA = data; WSTRB = strb; WLAST = last;
        WVALID = 1'b1;
        while (!WREADY && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 50) chk("w_timeout", {31'b0, WREADY}, 32'd1);
        @(posedge ACLK); #1;
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_collect(input string tag);
        int n = 0;
        b_exp_t e;
        BREADY = 1'b1;
        while (!BVALID && n < 50) begin
            @(posedge ACLK); #1;
            n++;
        end
        if (n >= 50) chk({tag, "_b_timeout"}, {31'b0, BVALID}, 32'd1);
        if (b_q.size() == 0) begin
            chk({tag, "_b_unexpected"}, {31'b0, BVALID}, 32'd0);
        end else begin
            e = b_q.pop_front();
            chk({tag, "_bid"},   {28'b0, BID},   {28'b0, e.id});
            chk({tag, "_bresp"}, {30'b0, BRESP}, {30'b0, e.resp});
        end
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic mem_drain(input string tag);
        mem_exp_t e;
        while (mem_q.size() > 0) begin
            e = mem_q.pop_front();
            rd_addr = e.idx;
            @(posedge ACLK); #1;
            chk($sformatf("%s_word%0d", tag, e.idx), rd_data, e.data);
        end
    endtask

    task automatic wr_single(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] wid,
                             input logic [31:0] data, input logic [3:0] strb, input logic [1:0] resp);
        int w;
        b_q.push_back('{id: id, resp: resp});
        aw_send(id, addr, 4'd0, 3'd2, BURST_INCR, w);
        w_beat(wid, data, strb, 1'b1);
        b_collect("single");
    endtask

    initial begin
        logic [31:0] dat[4];
        int          w;
        logic        seen_b;

        ARESET = 1'b1;
        AWID = 0; AWADDR = 0; AWLEN = 0; AWSIZE = 0; AWBURST = 0;
        AWLOCK = 0; AWCACHE = 0; AWPROT = 0; AWVALID = 0;
        WID = 0; WDATA = 0; WSTRB = 0; WLAST = 0; WVALID = 0;
        BREADY = 0; rd_addr = 0;
        repeat (3) @(posedge ACLK);
        #1;
        chk("rst_awready", {31'b0, AWREADY}, 32'd0);
        chk("rst_wready",  {31'b0, WREADY},  32'd0);
        chk("rst_bvalid",  {31'b0, BVALID},  32'd0);
        chk("rst_bid",     {28'b0, BID},     32'd0);
        chk("rst_bresp",   {30'b0, BRESP},   32'd0);
        chk("rst_rd_data", rd_data,          32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        chk("idle_awready", {31'b0, AWREADY}, 32'd1);

        // INCR burst into words 4..7
        dat = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002, 32'hA3A3_0003};
        b_q.push_back('{id: 4'd5, resp: RESP_OKAY});
        aw_send(4'd5, 32'h10, 4'd3, 3'd2, BURST_INCR, w);
        for (int i = 0; i < 4; i++) begin
            w_beat(4'd5, dat[i], 4'hF, i == 3);
            mem_q.push_back('{idx: 6'(4 + i), data: dat[i]});
        end
        b_collect("incr");
        mem_drain("incr");

        // WRAP burst starting at 0x18 lands on words 6,7,4,5
        dat = '{32'hD000_0000, 32'hD111_1111, 32'hD222_2222, 32'hD333_3333};
        b_q.push_back('{id: 4'd1, resp: RESP_OKAY});
        aw_send(4'd1, 32'h18, 4'd3, 3'd2, BURST_WRAP, w);
        for (int i = 0; i < 4; i++) w_beat(4'd1, dat[i], 4'hF, i == 3);
        mem_q.push_back('{idx: 6'd6, data: dat[0]});
        mem_q.push_back('{idx: 6'd7, data: dat[1]});
        mem_q.push_back('{idx: 6'd4, data: dat[2]});
        mem_q.push_back('{idx: 6'd5, data: dat[3]});
        b_collect("wrap");
        mem_drain("wrap");

        // Byte strobes over a preloaded word
        wr_single(4'd2, 32'h08, 4'd2, 32'hFFFF_FFFF, 4'hF, RESP_OKAY);
        wr_single(4'd2, 32'h08, 4'd2, 32'h1122_3344, 4'b0101, RESP_OKAY);
        mem_q.push_back('{idx: 6'd2, data: 32'hFF22_FF44});
        mem_drain("strb");

        // Out-of-window burst: words 0/1 (aliases of 0x100/0x104) stay put
        wr_single(4'd0, 32'h00, 4'd0, 32'h0BAD_0000, 4'hF, RESP_OKAY);
        wr_single(4'd0, 32'h04, 4'd0, 32'h0BAD_0001, 4'hF, RESP_OKAY);
        b_q.push_back('{id: 4'd7, resp: RESP_SLVERR});
        aw_send(4'd7, 32'h100, 4'd1, 3'd2, BURST_INCR, w);
        w_beat(4'd7, 32'hEEEE_0000, 4'hF, 1'b0);
        w_beat(4'd7, 32'hEEEE_0001, 4'hF, 1'b1);
        b_collect("oor");
        mem_q.push_back('{idx: 6'd0, data: 32'h0BAD_0000});
        mem_q.push_back('{idx: 6'd1, data: 32'h0BAD_0001});
        mem_drain("oor");

        // WID mismatch drops the beat and flags SLVERR
        wr_single(4'd6, 32'h28, 4'd6, 32'hCAFE_F00D, 4'hF, RESP_OKAY);
        wr_single(4'd6, 32'h28, 4'd7, 32'h0000_0000, 4'hF, RESP_SLVERR);
        mem_q.push_back('{idx: 6'd10, data: 32'hCAFE_F00D});
        mem_drain("wid");

        // Early WLAST on beat 2 of a 4-beat burst
        b_q.push_back('{id: 4'd3, resp: RESP_SLVERR});
        aw_send(4'd3, 32'h20, 4'd3, 3'd2, BURST_INCR, w);
        w_beat(4'd3, 32'h8888_0000, 4'hF, 1'b0);
        w_beat(4'd3, 32'h8888_0001, 4'hF, 1'b1);
        chk("early_last_wready", {31'b0, WREADY}, 32'd0);
        chk("early_last_bvalid", {31'b0, BVALID}, 32'd1);
        mem_q.push_back('{idx: 6'd8, data: 32'h8888_0000});
        mem_q.push_back('{idx: 6'd9, data: 32'h8888_0001});
        b_collect("early_last");
        mem_drain("early_last");

        // B backpressure, then back-to-back address
        aw_send(4'd9, 32'h30, 4'd0, 3'd2, BURST_INCR, w);
        w_beat(4'd9, 32'h9999_9999, 4'hF, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("hold_bvalid",  {31'b0, BVALID},  32'd1);
            chk("hold_bid",     {28'b0, BID},     32'd9);
            chk("hold_bresp",   {30'b0, BRESP},   {30'b0, RESP_OKAY});
            chk("hold_awready", {31'b0, AWREADY}, 32'd0);
            @(posedge ACLK); #1;
        end
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
        chk("post_b_bvalid",  {31'b0, BVALID},  32'd0);
        chk("post_b_awready", {31'b0, AWREADY}, 32'd0);
        b_q.push_back('{id: 4'd4, resp: RESP_OKAY});
        aw_send(4'd4, 32'h34, 4'd0, 3'd2, BURST_INCR, w);
        chk("bubble_waits", 32'(w), 32'd1);
        w_beat(4'd4, 32'h4444_4444, 4'hF, 1'b1);
        b_collect("b2b");
        mem_q.push_back('{idx: 6'd12, data: 32'h9999_9999});
        mem_q.push_back('{idx: 6'd13, data: 32'h4444_4444});
        mem_drain("b2b");

        // Reset after the second beat of a 4-beat burst
        aw_send(4'd2, 32'h40, 4'd3, 3'd2, BURST_INCR, w);
        w_beat(4'd2, 32'h5555_0001, 4'hF, 1'b0);
        w_beat(4'd2, 32'h5555_0002, 4'hF, 1'b0);
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        chk("midrst_awready", {31'b0, AWREADY}, 32'd0);
        chk("midrst_wready",  {31'b0, WREADY},  32'd0);
        chk("midrst_bvalid",  {31'b0, BVALID},  32'd0);
        chk("midrst_bid",     {28'b0, BID},     32'd0);
        chk("midrst_bresp",   {30'b0, BRESP},   32'd0);
        chk("midrst_rd_data", rd_data,          32'd0);
        seen_b = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge ACLK); #1;
            seen_b = seen_b | BVALID;
        end
        chk("midrst_no_b",    {31'b0, seen_b},  32'd0);
        chk("midrst_awready_back", {31'b0, AWREADY}, 32'd1);
        mem_q.push_back('{idx: 6'd16, data: 32'h5555_0001});
        mem_q.push_back('{idx: 6'd17, data: 32'h5555_0002});
        mem_drain("midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
